// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: turns request levels into count-enable, clear
// and display-freeze controls, with lap hold, auto-stop at 59:59 and pause timeout.
module stopwatch_ctrl #(
  parameter int LAP_HOLD     = 3,
  parameter int IDLE_TIMEOUT = 60,
  parameter int STOP_AT_MAX  = 1
) (
  input  logic       clk1sec,
  input  logic       rst,
  input  logic       mode_active,
  input  logic       ss_req,
  input  logic       lap_req,
  input  logic       clr_req,
  input  logic [3:0] tenmin,
  input  logic [3:0] onemin,
  input  logic [3:0] tensec,
  input  logic [3:0] onesec,
  output logic       run_en,
  output logic       clr,
  output logic       freeze,
  output logic [1:0] state,
  output logic       at_max,
  output logic [3:0] lap_count
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_LAP   = 2'b11;

  localparam logic [3:0] HOLD_LOAD     = 4'(LAP_HOLD);
  localparam logic [7:0] IDLE_LAST     = 8'(IDLE_TIMEOUT - 1);
  localparam bit         TIMEOUT_EN    = (IDLE_TIMEOUT != 0);
  localparam bit         AUTO_STOP_EN  = (STOP_AT_MAX != 0);

  logic [1:0] state_q, state_d;
  logic [3:0] lap_q, lap_d;
  logic [3:0] hold_q, hold_d;
  logic [7:0] idle_q, idle_d;
  logic       at_max_q, at_max_d;
  logic       clr_q, clr_d;
  logic       run_en_q, freeze_q;
  logic       ss_hist_q, lap_hist_q, clr_hist_q;

  logic ss_ev, lap_ev, clr_ev, auto_stop;

  function automatic logic [3:0] lap_inc(input logic [3:0] c);
    return (c >= 4'd9) ? c : c + 4'd1;
  endfunction

  function automatic logic [7:0] idle_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  always_comb begin
    ss_ev     = mode_active & ss_req  & ~ss_hist_q;
    lap_ev    = mode_active & lap_req & ~lap_hist_q;
    clr_ev    = mode_active & clr_req & ~clr_hist_q;
    // Digits one step short of 59:59: the datapath lands on 59:59 this edge and holds
    auto_stop = AUTO_STOP_EN && (tenmin == 4'd5) && (onemin == 4'd9) &&
                (tensec == 4'd5) && (onesec == 4'd8);
  end

  always_comb begin
    state_d  = state_q;
    lap_d    = lap_q;
    hold_d   = hold_q;
    idle_d   = idle_q;
    at_max_d = at_max_q;
    clr_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clr_ev) begin
          clr_d = 1'b1;
          lap_d = 4'd0;
        end else if (ss_ev) begin
          state_d  = S_RUN;
          at_max_d = 1'b0;
        end
      end
      S_RUN: begin
        if (clr_ev) begin
          state_d = S_IDLE;
          clr_d   = 1'b1;
          lap_d   = 4'd0;
        end else if (ss_ev) begin
          state_d = S_PAUSE;
          idle_d  = 8'd0;
        end else if (auto_stop) begin
          state_d  = S_PAUSE;
          idle_d   = 8'd0;
          at_max_d = 1'b1;
        end else if (lap_ev) begin
          state_d = S_LAP;
          lap_d   = lap_inc(lap_q);
          hold_d  = HOLD_LOAD;
        end
      end
      S_LAP: begin
        if (clr_ev) begin
          state_d = S_IDLE;
          clr_d   = 1'b1;
          lap_d   = 4'd0;
        end else if (ss_ev) begin
          state_d = S_PAUSE;
          idle_d  = 8'd0;
        end else if (auto_stop) begin
          state_d  = S_PAUSE;
          idle_d   = 8'd0;
          at_max_d = 1'b1;
        end else if (lap_ev) begin
          lap_d  = lap_inc(lap_q);
          hold_d = HOLD_LOAD;
        end else if (hold_q <= 4'd1) begin
          state_d = S_RUN;
          hold_d  = 4'd0;
        end else begin
          hold_d = hold_q - 4'd1;
        end
      end
      default: begin
        if (clr_ev) begin
          state_d = S_IDLE;
          clr_d   = 1'b1;
          lap_d   = 4'd0;
        end else if (ss_ev) begin
          state_d  = S_RUN;
          idle_d   = 8'd0;
          at_max_d = 1'b0;
        end else if (TIMEOUT_EN && (idle_q == IDLE_LAST)) begin
          state_d = S_IDLE;
          clr_d   = 1'b1;
          lap_d   = 4'd0;
        end else begin
          idle_d = idle_inc(idle_q);
        end
      end
    endcase
  end

  always_ff @(posedge clk1sec) begin
    if (rst) begin
      state_q    <= S_IDLE;
      lap_q      <= 4'd0;
      hold_q     <= 4'd0;
      idle_q     <= 8'd0;
      at_max_q   <= 1'b0;
      clr_q      <= 1'b0;
      run_en_q   <= 1'b0;
      freeze_q   <= 1'b0;
      // History starts high so a request held through reset is not an edge
      ss_hist_q  <= 1'b1;
      lap_hist_q <= 1'b1;
      clr_hist_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      lap_q      <= lap_d;
      hold_q     <= hold_d;
      idle_q     <= idle_d;
      at_max_q   <= at_max_d;
      clr_q      <= clr_d;
      run_en_q   <= (state_d == S_RUN) || (state_d == S_LAP);
      freeze_q   <= (state_d == S_LAP);
      ss_hist_q  <= ss_req;
      lap_hist_q <= lap_req;
      clr_hist_q <= clr_req;
    end
  end

  assign state     = state_q;
  assign lap_count = lap_q;
  assign at_max    = at_max_q;
  assign clr       = clr_q;
  assign run_en    = run_en_q;
  assign freeze    = freeze_q;

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Sequencing controller for the MM:SS stopwatch datapath. Turns user request levels into count-enable, clear and display-freeze controls.
- Adds lap hold with auto-release, a saturating lap counter, optional auto-stop before 59:59 wraps, and auto-clear after a long pause.
- Sits between the button/mode logic and the stopwatch digit counters.
- Runs entirely on the 1 Hz tick clock.

Parameters:
- LAP_HOLD, 3, seconds the display stays frozen after a lap request (1..15).
- IDLE_TIMEOUT, 60, seconds in PAUSE before auto-clear to IDLE; 0 disables (0..255).
- STOP_AT_MAX, 1, 1 = stop counting at 59:59; 0 = let the datapath wrap to 00:00.

Ports:
- clk1sec, input, 1, 1 Hz tick clock; all logic on its rising edge.
- rst, input, 1, reset.
- mode_active, input, 1, stopwatch mode selected; requests are ignored when 0.
- ss_req, input, 1, start/stop request level, held high at least 1 clk1sec cycle upstream.
- lap_req, input, 1, lap request level.
- clr_req, input, 1, clear request level.
- tenmin, input, 4, datapath tens-of-minutes digit.
- onemin, input, 4, datapath minutes digit.
- tensec, input, 4, datapath tens-of-seconds digit.
- onesec, input, 4, datapath seconds digit.
- run_en, output, 1, datapath count enable.
- clr, output, 1, one-cycle datapath clear pulse.
- freeze, output, 1, display hold (lap view).
- state, output, 2, IDLE=00, RUN=01, PAUSE=10, LAP=11.
- at_max, output, 1, auto-stop occurred.
- lap_count, output, 4, laps taken, 0..9, saturating.

Behaviour:
- Reset: rst is synchronous, active-high, clock clk1sec.
  - On reset: state=IDLE; run_en=0, clr=0, freeze=0, at_max=0, lap_count=0; hold and idle counters = 0.
  - Request history registers reset to 1, so a request held high through reset is not an edge.
  - rst overrides everything, including a mid-lap or mid-pause sequence.
- Edge detection: a request event is req=1 at edge k with req=0 at edge k-1.
  - History registers update every cycle, even when mode_active=0.
  - Events are discarded when mode_active=0; state and counting continue.
- Latency: all outputs are registered. An event sampled at edge k is reflected after edge k (0-cycle latency from the sampling edge).
- Priority of simultaneous events: clr > ss > lap. Only the highest-priority event acts.
- Derived outputs: run_en=1 exactly in RUN and LAP. freeze=1 exactly in LAP.
- IDLE:
  - ss -> RUN, at_max=0.
  - clr -> clr pulse, lap_count=0, stay in IDLE.
  - lap ignored.
- RUN:
  - ss -> PAUSE.
  - lap -> LAP; lap_count+1 (saturate at 9); hold counter = LAP_HOLD.
  - clr -> IDLE with clr pulse, lap_count=0.
- LAP (datapath keeps counting):
  - Hold counter decrements each cycle; on the cycle it would reach 0 -> RUN.
  - lap -> stay in LAP, lap_count+1 (saturating), hold counter reloads to LAP_HOLD.
  - ss -> PAUSE. clr -> IDLE with clr pulse.
- PAUSE:
  - Idle counter increments each cycle, saturating.
  - ss -> RUN, idle counter=0, at_max=0.
  - lap ignored.
  - clr -> IDLE with clr pulse, lap_count=0.
  - Idle counter == IDLE_TIMEOUT-1 with no event (IDLE_TIMEOUT != 0) -> IDLE with clr pulse, lap_count=0.
  - The idle counter clears on every PAUSE entry.
- Auto-stop (STOP_AT_MAX=1):
  - Trigger: in RUN or LAP, digits equal 5,9,5,8 at an edge with no clr/ss event.
  - Effect: -> PAUSE, at_max=1, freeze=0.
  - The datapath completes its step to 59:59 on that same edge and then holds, because run_en is now 0.
  - A later ss from PAUSE restarts; the datapath wraps to 00:00.
- clr is never asserted two consecutive cycles unless clr events recur.
- Digit inputs are compared only; no arithmetic is done on them.
- All counters are unsigned and saturating; none wraps.

Test Plan:
- Reset then ss pulse at cycle 2 -> state=01, run_en=1 after edge 2. Second ss at cycle 10 -> state=10, run_en=0.
- In RUN, lap pulse with LAP_HOLD=3 -> freeze=1, lap_count=1, for exactly 3 cycles, then state=01, freeze=0. Ten laps -> lap_count stays 9.
- ss, lap and clr high together in RUN -> clr=1 for one cycle, state=00, lap_count=0, run_en=0.
- In RUN, drive digits 5,9,5,8 -> next state=10, at_max=1, run_en=0. With STOP_AT_MAX=0, state stays 01.
- Pause with IDLE_TIMEOUT=4 and no events -> after 4 cycles in PAUSE, clr pulse and state=00. An ss at the 3rd cycle prevents the auto-clear.
- ss held high across rst release -> no transition. With mode_active=0 an ss pulse is ignored; ss pulsed after mode_active=1 is accepted.
